// File: rtl/fpalu_div_if.sv
// Handshake and data bundle for the single-precision divider.
// The master drives the request, the slave returns the quotient and status flags.
interface fpalu_div_if;
  logic        start;
  logic [31:0] a_input;
  logic [31:0] b_input;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        div_by_zero;
  logic        invalid;

  modport master (
    output start, a_input, b_input,
    input  busy, done, result, overflow, underflow, div_by_zero, invalid
  );

  modport slave (
    input  start, a_input, b_input,
    output busy, done, result, overflow, underflow, div_by_zero, invalid
  );
endinterface

// File: rtl/fpalu_div.sv
// Multi-cycle IEEE-754 single-precision divider using a restoring radix-2 datapath.
// Define FPALU_DIV_ROUND_EN for round-to-nearest-even; otherwise the quotient is truncated.
module fpalu_div (
  input  logic       clock,
  input  logic       reset,
  fpalu_div_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StUnpack,
    StDivide,
    StNorm,
    StRound,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [24:0]        rem_q, rem_d;
  logic [25:0]        quo_q, quo_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [23:0]        mant_q, mant_d;
  logic               guard_q, guard_d;
  logic               sticky_q, sticky_d;
  logic [31:0]        result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               dbz_q, dbz_d;
  logic               inv_q, inv_d;

  // Operand classification
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic        is_special, sign_u;
  logic [31:0] spec_res;
  logic        spec_inv, spec_dbz;
  logic [23:0] ma, mb;
  logic signed [9:0] exp_unpack;

  assign ea     = a_q[30:23];
  assign eb     = b_q[30:23];
  assign fa     = a_q[22:0];
  assign fb     = b_q[22:0];
  assign sign_u = a_q[31] ^ b_q[31];
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
  assign ma     = {1'b1, fa};
  assign mb     = {1'b1, fb};
  assign is_special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
  assign exp_unpack = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;

  always_comb begin
    spec_res = {sign_u, 31'd0};
    spec_inv = 1'b0;
    spec_dbz = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res = 32'h7FC0_0000;
      spec_inv = 1'b1;
    end else if (a_inf) begin
      spec_res = {sign_u, 8'hFF, 23'd0};
    end else if (b_zero) begin
      spec_res = {sign_u, 8'hFF, 23'd0};
      spec_dbz = 1'b1;
    end
  end

  // Restoring divide step
  logic        rem_ge;
  logic [24:0] rem_sub, rem_keep;

  assign rem_ge   = (rem_q >= {1'b0, mb});
  assign rem_sub  = rem_q - {1'b0, mb};
  assign rem_keep = rem_ge ? rem_sub : rem_q;

  // Rounding and final packing
  logic              round_inc;
  logic [24:0]       mant_sum;
  logic [23:0]       mant_rnd;
  logic signed [9:0] exp_rnd;

`ifdef FPALU_DIV_ROUND_EN
  assign round_inc = guard_q & (sticky_q | mant_q[0]);
`else
  logic unused_round_bits;
  assign unused_round_bits = guard_q ^ sticky_q;
  assign round_inc = 1'b0;
`endif

  assign mant_sum = {1'b0, mant_q} + {24'd0, round_inc};
  assign mant_rnd = mant_sum[24] ? 24'h80_0000 : mant_sum[23:0];
  assign exp_rnd  = mant_sum[24] ? (exp_q + 10'sd1) : exp_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    mant_d   = mant_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    dbz_d    = dbz_q;
    inv_d    = inv_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.a_input;
          b_d     = bus.b_input;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          dbz_d   = 1'b0;
          inv_d   = 1'b0;
          cnt_d   = 5'd0;
          state_d = StUnpack;
        end
      end
      StUnpack: begin
        if (is_special) begin
          // Specials dwell one extra cycle so their result lands after the second edge
          if (cnt_q == 5'd0) begin
            cnt_d = 5'd1;
          end else begin
            result_d = spec_res;
            inv_d    = spec_inv;
            dbz_d    = spec_dbz;
            cnt_d    = 5'd0;
            state_d  = StDone;
          end
        end else begin
          sign_d  = sign_u;
          exp_d   = exp_unpack;
          rem_d   = {1'b0, ma};
          quo_d   = 26'd0;
          cnt_d   = 5'd0;
          state_d = StDivide;
        end
      end
      StDivide: begin
        quo_d = {quo_q[24:0], rem_ge};
        rem_d = {rem_keep[23:0], 1'b0};
        if (cnt_q == 5'd25) begin
          cnt_d   = 5'd0;
          state_d = StNorm;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StNorm: begin
        if (quo_q[25]) begin
          mant_d   = quo_q[25:2];
          guard_d  = quo_q[1];
          sticky_d = quo_q[0] | (rem_q != 25'd0);
        end else begin
          mant_d   = quo_q[24:1];
          guard_d  = quo_q[0];
          sticky_d = (rem_q != 25'd0);
          exp_d    = exp_q - 10'sd1;
        end
        state_d = StRound;
      end
      StRound: begin
        if (exp_rnd >= 10'sd255) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          ovf_d    = 1'b1;
        end else if (exp_rnd <= 10'sd0) begin
          result_d = {sign_q, 31'd0};
          unf_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_rnd[7:0], mant_rnd[22:0]};
        end
        state_d = StDone;
      end
      StDone: begin
        cnt_d   = 5'd0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      sign_q   <= 1'b0;
      exp_q    <= 10'sd0;
      rem_q    <= 25'd0;
      quo_q    <= 26'd0;
      cnt_q    <= 5'd0;
      mant_q   <= 24'd0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      result_q <= 32'd0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      mant_q   <= mant_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dbz_q    <= dbz_d;
      inv_q    <= inv_d;
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = (state_q == StDone);
  assign bus.result      = result_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.invalid     = inv_q;

endmodule

// File: tb/tb_fpalu_div.sv
// Self-checking bench for fpalu_div: directed corner cases plus random operands
// compared against an integer-arithmetic reference of the divider's rules.
module tb_fpalu_div;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  fpalu_div_if bus ();

  fpalu_div dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {bus.overflow, bus.underflow, bus.div_by_zero, bus.invalid};
  endfunction

  // Reference: flags are {overflow, underflow, div_by_zero, invalid}
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [3:0] f, output int lat);
    int          ea, eb, e;
    logic        s, az, bz, ainf, binf, anan, bnan, g, st;
    longint      ma, mb, num, q, mant;
    ea   = int'(a[30:23]);
    eb   = int'(b[30:23]);
    s    = a[31] ^ b[31];
    az   = (ea == 0);
    bz   = (eb == 0);
    ainf = (ea == 255) && (a[22:0] == 0);
    binf = (eb == 255) && (b[22:0] == 0);
    anan = (ea == 255) && (a[22:0] != 0);
    bnan = (eb == 255) && (b[22:0] != 0);
    f    = 4'b0000;
    lat  = 2;
    if (anan || bnan || (az && bz) || (ainf && binf)) begin
      r = 32'h7FC0_0000;
      f = 4'b0001;
    end else if (ainf) begin
      r = {s, 31'h7F80_0000};
    end else if (bz) begin
      r = {s, 31'h7F80_0000};
      f = 4'b0010;
    end else if (az || binf) begin
      r = {s, 31'd0};
    end else begin
      lat = 29;
      ma  = longint'({1'b1, a[22:0]});
      mb  = longint'({1'b1, b[22:0]});
      num = ma << 25;
      q   = num / mb;
      st  = (num % mb) != 0;
      e   = ea - eb + 127;
      if (q >= (64'd1 << 25)) begin
        mant = q >> 2;
        g    = q[1];
        st   = st | q[0];
      end else begin
        mant = q >> 1;
        g    = q[0];
        e    = e - 1;
      end
`ifdef FPALU_DIV_ROUND_EN
      if (g && (st || mant[0])) mant = mant + 1;
`else
      if (g && st) mant = mant + 0;
`endif
      if (mant == (64'd1 << 24)) begin
        mant = 64'd1 << 23;
        e    = e + 1;
      end
      if (e >= 255) begin
        r = {s, 31'h7F80_0000};
        f = 4'b1000;
      end else if (e <= 0) begin
        r = {s, 31'd0};
        f = 4'b0100;
      end else begin
        r = {s, e[7:0], mant[22:0]};
      end
    end
  endtask

  // Accept one operation, then wait (bounded) for done and check everything
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic [3:0]  ef;
    int          el, lat;
    model(a, b, er, ef, el);
    bus.start   = 1'b1;
    bus.a_input = a;
    bus.b_input = b;
    @(posedge clock); #1;
    bus.start   = 1'b0;
    bus.a_input = $urandom;
    bus.b_input = $urandom;
    chk({tag, " busy_after_accept"}, 32'(bus.busy), 32'd1);
    chk({tag, " flags_clear"}, 32'(flags()), 32'd0);
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(el));
    chk({tag, " result"}, bus.result, er);
    chk({tag, " flags"}, 32'(flags()), 32'(ef));
    chk({tag, " busy_in_done"}, 32'(bus.busy), 32'd1);
    @(posedge clock); #1;
    chk({tag, " done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, " held"}, bus.result, er);
  endtask

  logic [31:0] ra, rb;
  int          dcnt, lat2;

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.a_input = 32'd0;
    bus.b_input = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst result", bus.result, 32'd0);
    chk("rst flags", 32'(flags()), 32'd0);
    reset = 1'b0;

    run_op("6/2", 32'h40C0_0000, 32'h4000_0000);
    chk("6/2 const", bus.result, 32'h4040_0000);
    run_op("1/3", 32'h3F80_0000, 32'h4040_0000);
`ifdef FPALU_DIV_ROUND_EN
    chk("1/3 const", bus.result, 32'h3EAA_AAAB);
`else
    chk("1/3 const", bus.result, 32'h3EAA_AAAA);
`endif
    run_op("1/0", 32'h3F80_0000, 32'h0000_0000);
    chk("1/0 const", bus.result, 32'h7F80_0000);
    run_op("-1/0", 32'hBF80_0000, 32'h0000_0000);
    chk("-1/0 const", bus.result, 32'hFF80_0000);
    run_op("0/0", 32'h0000_0000, 32'h0000_0000);
    run_op("inf/inf", 32'h7F80_0000, 32'hFF80_0000);
    run_op("nan/1", 32'h7FC0_1234, 32'h3F80_0000);
    run_op("inf/2", 32'hFF80_0000, 32'h4000_0000);
    run_op("0/3", 32'h8000_0000, 32'h4040_0000);
    run_op("3/inf", 32'h4040_0000, 32'h7F80_0000);
    run_op("denorm/2", 32'h0000_0001, 32'h4000_0000);
    run_op("ovf", 32'h7F00_0000, 32'h3F00_0000);
    run_op("unf", 32'h0080_0000, 32'h4000_0000);
    run_op("neg", 32'hC0C0_0000, 32'h4040_0000);

    // Reset aborts an operation in flight; start on the reset edge is ignored
    bus.start   = 1'b1;
    bus.a_input = 32'h40C0_0000;
    bus.b_input = 32'h4000_0000;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset     = 1'b1;
    bus.start = 1'b1;
    @(posedge clock); #1;
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort result", bus.result, 32'd0);
    reset     = 1'b0;
    bus.start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (bus.done || bus.busy) dcnt++;
    end
    chk("abort no_done", 32'(dcnt), 32'd0);
    run_op("6/2 after abort", 32'h40C0_0000, 32'h4000_0000);

    // Start held high: second operands are not taken until after done
    bus.start   = 1'b1;
    bus.a_input = 32'h40C0_0000;
    bus.b_input = 32'h4000_0000;
    @(posedge clock); #1;
    bus.a_input = 32'h3F80_0000;
    bus.b_input = 32'h4040_0000;
    lat2 = 0;
    while (!bus.done && lat2 < 100) begin
      @(posedge clock); #1;
      lat2++;
    end
    chk("hold latency", 32'(lat2), 32'd29);
    chk("hold first", bus.result, 32'h4040_0000);
    @(posedge clock); #1;
    chk("hold idle_gap", 32'(bus.busy), 32'd0);
    run_op("hold second", 32'h3F80_0000, 32'h4040_0000);

    // Random operands with mostly normal exponents and occasional specials
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) != 0) ra[30:23] = 8'($urandom_range(1, 254));
      if ($urandom_range(0, 7) != 0) rb[30:23] = 8'($urandom_range(1, 254));
      run_op($sformatf("rand%0d", n), ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
